// File: rtl/spm_pkg.sv
// Shared definitions for the bit-serial arithmetic path.
// Used by the serializer, the serial-parallel multiplier and the deserializer.
package spm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spm_state_e;

    // A serial frame is the operand followed by its sign-extension tail.
    function automatic int frame_len(input int width, input int ext);
        return width + ext;
    endfunction

    // Counter width that can hold any bit index 0..len-1 and also len itself.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/spm_ser_shreg.sv
// Loadable arithmetic right-shift register: the MSB replicates on every shift,
// so once the operand bits are out the LSB carries the sign extension.
module spm_ser_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end else if (shift_i) begin
            q_q <= {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/spm_serializer.sv
// Parallel-to-serial front end: signed word in, LSB-first frame of WIDTH+EXT bits out.
// Optional feature macro SPM_SERIALIZER_PRELOAD_EN adds a one-word holding register for gapless frames.
module spm_serializer
    import spm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s_en,
    output logic             s_valid,
    output logic             s_bit,
    output logic             s_first,
    output logic             s_last
);

    localparam int L  = frame_len(WIDTH, EXT);
    localparam int CW = cnt_width(L);
    localparam logic [CW-1:0] LAST_K = CW'(L - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("spm_serializer: WIDTH must be at least 2");
    end

    // Handshake: a word moves on a rising edge with in_valid && in_ready; a serial bit
    // moves downstream on a rising edge with s_valid && s_en, otherwise everything holds.
    spm_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_d, sh_q;
    logic             sh_load, sh_shift;
    logic             accept, xfer, at_last;

`ifdef SPM_SERIALIZER_PRELOAD_EN
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    assign in_ready = !hold_full_q;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept  = in_valid && in_ready;
    assign xfer    = s_valid && s_en;
    assign at_last = (cnt_q == LAST_K);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = in_data;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
`ifdef SPM_SERIALIZER_PRELOAD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                end
            end
            SHIFT: begin
                if (xfer && at_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef SPM_SERIALIZER_PRELOAD_EN
                    // Chain the next frame with no bubble; a full hold blocks accept.
                    if (hold_full_q) begin
                        state_d     = SHIFT;
                        sh_d        = hold_q;
                        sh_load     = 1'b1;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        state_d = SHIFT;
                        sh_load = 1'b1;
                    end
`endif
                end else if (xfer) begin
                    cnt_d    = cnt_q + CW'(1);
                    sh_shift = 1'b1;
                end
`ifdef SPM_SERIALIZER_PRELOAD_EN
                if (accept && !(xfer && at_last)) begin
                    hold_d      = in_data;
                    hold_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SPM_SERIALIZER_PRELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    spm_ser_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load_i (sh_load),
        .shift_i(sh_shift),
        .d_i    (sh_d),
        .q_o    (sh_q)
    );

    assign s_valid = (state_q == SHIFT);
    assign s_bit   = sh_q[0];
    assign s_first = s_valid && (cnt_q == '0);
    assign s_last  = s_valid && at_last;

endmodule

// File: tb/tb_spm_serializer.sv
// Directed bench for spm_serializer (WIDTH=8, EXT=8); expectations adapt to SPM_SERIALIZER_PRELOAD_EN.
module tb_spm_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       s_en;
    logic       s_valid;
    logic       s_bit;
    logic       s_first;
    logic       s_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spm_serializer #(
        .WIDTH(8),
        .EXT  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .s_en    (s_en),
        .s_valid (s_valid),
        .s_bit   (s_bit),
        .s_first (s_first),
        .s_last  (s_last)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return one cycle after the edge that accepted it.
    task automatic accept_word(input logic [7:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL accept_timeout word=%h in_ready=%b required=1", w, in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        s_en     = 1'b1;
        repeat (2) tick();
        total++;
        if ({s_valid, s_bit, s_first, s_last, in_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_state got v/b/f/l/r=%b required=00001",
                     {s_valid, s_bit, s_first, s_last, in_ready});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame;
        logic [15:0] exp_frame;
        exp_frame = 16'hFFA5;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready_idle got=%b required=1", in_ready);
        end
        accept_word(8'hA5);
        for (int k = 0; k < 16; k++) begin
            total++;
            if ({s_valid, s_bit, s_first, s_last, in_ready} !==
                {1'b1, exp_frame[k], k == 0, k == 15, 1'b0}) begin
                bad++;
                $display("FAIL basic_bit%0d got v/b/f/l/r=%b required=%b", k,
                         {s_valid, s_bit, s_first, s_last, in_ready},
                         {1'b1, exp_frame[k], k == 0, k == 15, 1'b0});
            end
            tick();
        end
        total++;
        if ({s_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL basic_end got v/r=%b required=01", {s_valid, in_ready});
        end
    endtask

    task automatic test_sign_tail;
        logic [15:0] exp_frame;
        exp_frame = 16'h0005;
        accept_word(8'h05);
        for (int k = 0; k < 16; k++) begin
            total++;
            if ({s_valid, s_bit, s_first, s_last, in_ready} !==
                {1'b1, exp_frame[k], k == 0, k == 15, 1'b0}) begin
                bad++;
                $display("FAIL tail_bit%0d got v/b/f/l/r=%b required=%b", k,
                         {s_valid, s_bit, s_first, s_last, in_ready},
                         {1'b1, exp_frame[k], k == 0, k == 15, 1'b0});
            end
            tick();
        end
        total++;
        if ({s_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL tail_end got v/r=%b required=01", {s_valid, in_ready});
        end
    endtask

    task automatic test_stall;
        logic [15:0] exp_frame;
        exp_frame = 16'hFFC3;
        accept_word(8'hC3);
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                s_en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    total++;
                    if ({s_valid, s_bit, s_first, s_last} !== {1'b1, exp_frame[3], 2'b00}) begin
                        bad++;
                        $display("FAIL stall_hold%0d got v/b/f/l=%b required=%b", s,
                                 {s_valid, s_bit, s_first, s_last}, {1'b1, exp_frame[3], 2'b00});
                    end
                end
                s_en = 1'b1;
            end
            total++;
            if ({s_valid, s_bit, s_first, s_last} !== {1'b1, exp_frame[k], k == 0, k == 15}) begin
                bad++;
                $display("FAIL stall_bit%0d got v/b/f/l=%b required=%b", k,
                         {s_valid, s_bit, s_first, s_last}, {1'b1, exp_frame[k], k == 0, k == 15});
            end
            tick();
        end
        total++;
        if (s_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_end s_valid got=%b required=0", s_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [39:0] ov, ob, of, ol;
        logic [39:0] ev, eb, ef, el;
        logic [15:0] w1, w2;
        int          gap, f2;
`ifdef SPM_SERIALIZER_PRELOAD_EN
        gap = 0;
`else
        gap = 1;
`endif
        w1 = 16'h0001;
        w2 = 16'hFF80;
        f2 = 17 + gap;
        fork
            begin
                accept_word(8'h01);
                accept_word(8'h80);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    ov[c] = s_valid;
                    ob[c] = s_bit;
                    of[c] = s_first;
                    ol[c] = s_last;
                    tick();
                end
            end
        join
        ev = '0;
        eb = '0;
        ef = '0;
        el = '0;
        for (int c = 0; c < 40; c++) begin
            if (c >= 1 && c <= 16) begin
                ev[c] = 1'b1;
                eb[c] = w1[c-1];
                ef[c] = (c == 1);
                el[c] = (c == 16);
            end else if (c >= f2 && c <= f2 + 15) begin
                ev[c] = 1'b1;
                eb[c] = w2[c-f2];
                ef[c] = (c == f2);
                el[c] = (c == f2 + 15);
            end
        end
        total++;
        if (ov !== ev) begin
            bad++;
            $display("FAIL b2b_valid got=%h required=%h", ov, ev);
        end
        total++;
        if ((ob & ev) !== eb) begin
            bad++;
            $display("FAIL b2b_bits got=%h required=%h", ob & ev, eb);
        end
        total++;
        if (of !== ef) begin
            bad++;
            $display("FAIL b2b_first got=%h required=%h", of, ef);
        end
        total++;
        if (ol !== el) begin
            bad++;
            $display("FAIL b2b_last got=%h required=%h", ol, el);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] exp_frame;
        accept_word(8'h3C);
        repeat (5) tick();
        total++;
        if ({s_valid, s_bit, s_first, s_last} !== 4'b1100) begin
            bad++;
            $display("FAIL midrst_bit5 got v/b/f/l=%b required=1100",
                     {s_valid, s_bit, s_first, s_last});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({s_valid, s_bit, s_first, s_last} !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_async got v/b/f/l=%b required=0000",
                     {s_valid, s_bit, s_first, s_last});
        end
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        exp_frame = 16'hFF97;
        accept_word(8'h97);
        for (int k = 0; k < 16; k++) begin
            total++;
            if ({s_valid, s_bit, s_first, s_last} !== {1'b1, exp_frame[k], k == 0, k == 15}) begin
                bad++;
                $display("FAIL midrst_restart_bit%0d got v/b/f/l=%b required=%b", k,
                         {s_valid, s_bit, s_first, s_last}, {1'b1, exp_frame[k], k == 0, k == 15});
            end
            tick();
        end
    endtask

    // Downstream serial negation: pass bits through the first 1, invert the rest.
    task automatic test_twos_complement;
        logic [15:0] neg;
        logic        seen;
        seen = 1'b0;
        neg  = '0;
        accept_word(8'h03);
        for (int k = 0; k < 16; k++) begin
            if (s_first) seen = 1'b0;
            neg[k] = s_bit ^ seen;
            seen   = seen | s_bit;
            tick();
        end
        total++;
        if (neg !== 16'hFFFD) begin
            bad++;
            $display("FAIL twos_complement got=%h required=FFFD", neg);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_sign_tail();
        test_stall();
        tick();
        test_back_to_back();
        test_reset_mid_frame();
        tick();
        test_twos_complement();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
